// File: rtl/mult_nibble_sequencer.sv
// Multi-cycle WIDTH x WIDTH unsigned multiplier built around one shared 4x4 array_multiplier.
// Optional build macro: MULT_ZERO_SKIP_EN (zero operand goes straight to DONE with product 0).

module array_multiplier (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [7:0] row [4];

  // One shifted copy of a per set bit of b, summed as in a classic array multiplier.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_row
      assign row[gi] = b[gi] ? ({4'b0000, a} << gi) : 8'd0;
    end
  endgenerate

  assign p = row[0] + row[1] + row[2] + row[3];
endmodule

module mult_nibble_sequencer #(
  parameter int NIB = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4*NIB-1:0] a,
  input  logic [4*NIB-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [8*NIB-1:0] product,
  output logic             busy
);
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIB - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_reg;
  logic [4*NIB-1:0]   a_reg, b_reg;
  logic [8*NIB-1:0]   acc_reg, product_reg;
  logic [IDX_W-1:0]   i_reg, j_reg;
  logic               in_ready_reg, out_valid_reg, busy_reg;

  logic [3:0]         a_nib, b_nib;
  logic [7:0]         pp;
  logic [IDX_W:0]     sum_idx;
  logic [8*NIB-1:0]   pp_ext, acc_next;

  assign a_nib = a_reg[4*i_reg +: 4];
  assign b_nib = b_reg[4*j_reg +: 4];

  array_multiplier u_mult (
    .a (a_nib),
    .b (b_nib),
    .p (pp)
  );

  // Partial product of nibbles i and j carries weight 2^(4*(i+j)).
  assign sum_idx  = {1'b0, i_reg} + {1'b0, j_reg};
  assign pp_ext   = (8*NIB)'(pp);
  assign acc_next = acc_reg + (pp_ext << {sum_idx, 2'b00});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      acc_reg       <= '0;
      product_reg   <= '0;
      i_reg         <= '0;
      j_reg         <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg        <= a;
            b_reg        <= b;
            acc_reg      <= '0;
            i_reg        <= '0;
            j_reg        <= '0;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
`ifdef MULT_ZERO_SKIP_EN
            if (a == '0 || b == '0) begin
              product_reg   <= '0;
              out_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end else begin
              state_reg <= CALC;
            end
`else
            state_reg <= CALC;
`endif
          end
        end
        CALC: begin
          acc_reg <= acc_next;
          // i is the fast index; the pair (LAST, LAST) is the final accumulate.
          if (i_reg == LAST) begin
            i_reg <= '0;
            if (j_reg == LAST) begin
              product_reg   <= acc_next;
              out_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end else begin
              j_reg <= j_reg + 1'b1;
            end
          end else begin
            i_reg <= i_reg + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign product   = product_reg;
  assign busy      = busy_reg;
endmodule
